// File: rtl/glb_strm_launch_ctrl.sv
// glb_strm_launch_ctrl
//   Launch scheduler for global_buffer tile kernels. Launch requests (kind + tile mask)
//   are queued in order. A request issues a one-cycle start pulse only when its tiles
//   are free. Per-tile busy state is tracked from interrupt pulses. Job completion and
//   timeout are reported per kind.
//
//   Ports
//     clk, reset                 clock, async active-high reset
//     flush                      sync clear of queue, busy, active and timers (no done)
//     cfg_timeout                cycles before an active job times out, 0 = disabled
//     req_valid/req_ready        request handshake (ready = queue not full)
//     req_kind, req_tile_mask    0=g2f 1=f2g 2=pcfg 3=illegal, target tiles
//     *_start_pulse              registered one-cycle start pulses to global_buffer
//     *_interrupt_pulse          completion pulses from global_buffer
//     busy_g2f/f2g/pcfg          per-tile outstanding kernel flags
//     done_pulse, done_err       per-kind job finished, done_err=1 if finished by timeout
//     err_illegal                sticky: an illegal-kind or zero-mask request was dropped

// Per-kind job tracker: active tile mask, timeout timer, done reporting.
// Only one job per kind can be active at once, so the active mask is also the
// per-tile busy vector for that kind.
module glb_strm_kind_trk #(
   parameter int NT        = 16,
   parameter int TMO_WIDTH = 24
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 flush,
   input  logic [TMO_WIDTH-1:0] cfg_timeout,
   input  logic                 launch,
   input  logic [NT-1:0]        launch_mask,
   input  logic [NT-1:0]        irq,
   output logic [NT-1:0]        active,
   output logic                 done,
   output logic                 done_err
);
   logic [TMO_WIDTH-1:0] timer;
   logic [NT-1:0]        act_nxt;
   logic                 tmo_hit;

   always_comb begin
      tmo_hit = (cfg_timeout != '0) && (active != '0) &&
                (timer == cfg_timeout - TMO_WIDTH'(1));
      // Interrupts on non-busy tiles fall out of the AND; a same-cycle launch set wins.
      act_nxt = tmo_hit ? '0 : (active & ~irq);
      if (launch) act_nxt = act_nxt | launch_mask;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         active   <= '0;
         timer    <= '0;
         done     <= 1'b0;
         done_err <= 1'b0;
      end else if (flush) begin
         active   <= '0;
         timer    <= '0;
         done     <= 1'b0;
         done_err <= 1'b0;
      end else begin
         active   <= act_nxt;
         done     <= (active != '0) && (act_nxt == '0);
         done_err <= tmo_hit;
         if (launch)
            timer <= '0;
         else if ((active != '0) && (timer != '1))
            timer <= timer + TMO_WIDTH'(1);
      end
   end
endmodule

module glb_strm_launch_ctrl #(
   parameter int NUM_GLB_TILES = 16,
   parameter int FIFO_DEPTH    = 4,
   parameter int TMO_WIDTH     = 24
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     flush,
   input  logic [TMO_WIDTH-1:0]     cfg_timeout,
   input  logic                     req_valid,
   output logic                     req_ready,
   input  logic [1:0]               req_kind,
   input  logic [NUM_GLB_TILES-1:0] req_tile_mask,
   output logic [NUM_GLB_TILES-1:0] strm_g2f_start_pulse,
   output logic [NUM_GLB_TILES-1:0] strm_f2g_start_pulse,
   output logic [NUM_GLB_TILES-1:0] pcfg_start_pulse,
   input  logic [NUM_GLB_TILES-1:0] strm_g2f_interrupt_pulse,
   input  logic [NUM_GLB_TILES-1:0] strm_f2g_interrupt_pulse,
   input  logic [NUM_GLB_TILES-1:0] pcfg_g2f_interrupt_pulse,
   output logic [NUM_GLB_TILES-1:0] busy_g2f,
   output logic [NUM_GLB_TILES-1:0] busy_f2g,
   output logic [NUM_GLB_TILES-1:0] busy_pcfg,
   output logic [2:0]               done_pulse,
   output logic [2:0]               done_err,
   output logic                     err_illegal
);
   localparam int NT = NUM_GLB_TILES;
   localparam int AW = $clog2(FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE, CHECK, LAUNCH} state_t;

   // ---------------- request queue ----------------
   logic [1:0]    q_kind [FIFO_DEPTH];
   logic [NT-1:0] q_mask [FIFO_DEPTH];
   logic [AW:0]   wr_ptr, rd_ptr, count;
   logic          empty, push, pop;
   logic [1:0]    hd_kind;
   logic [NT-1:0] hd_mask;

   assign count     = wr_ptr - rd_ptr;
   assign empty     = (count == '0);
   assign req_ready = (count != (AW+1)'(FIFO_DEPTH));
   assign push      = req_valid && req_ready;
   assign hd_kind   = q_kind[rd_ptr[AW-1:0]];
   assign hd_mask   = q_mask[rd_ptr[AW-1:0]];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
         if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
      end
   end

   // Storage needs no reset: entries are only read below the write pointer.
   always_ff @(posedge clk) begin
      if (push) begin
         q_kind[wr_ptr[AW-1:0]] <= req_kind;
         q_mask[wr_ptr[AW-1:0]] <= req_tile_mask;
      end
   end

   // ---------------- per-kind trackers ----------------
   logic [2:0][NT-1:0] act, irq, pulse;
   logic [2:0]         launch_k;

   assign irq[0] = strm_g2f_interrupt_pulse;
   assign irq[1] = strm_f2g_interrupt_pulse;
   assign irq[2] = pcfg_g2f_interrupt_pulse;

   for (genvar k = 0; k < 3; k++) begin : g_trk
      glb_strm_kind_trk #(.NT(NT), .TMO_WIDTH(TMO_WIDTH)) u_trk (
         .clk         (clk),
         .reset       (reset),
         .flush       (flush),
         .cfg_timeout (cfg_timeout),
         .launch      (launch_k[k]),
         .launch_mask (hd_mask),
         .irq         (irq[k]),
         .active      (act[k]),
         .done        (done_pulse[k]),
         .done_err    (done_err[k])
      );
   end

   assign busy_g2f  = act[0];
   assign busy_f2g  = act[1];
   assign busy_pcfg = act[2];

   // ---------------- head decode ----------------
   logic hd_illegal, blocked;

   always_comb begin
      hd_illegal = (hd_kind == 2'd3) || (hd_mask == '0);
      blocked    = 1'b0;
      case (hd_kind)
         2'd0:    blocked = (act[0] != '0) || ((hd_mask & act[2]) != '0);
         2'd1:    blocked = (act[1] != '0) || ((hd_mask & act[2]) != '0);
         2'd2:    blocked = (act[2] != '0) || ((hd_mask & (act[0] | act[1] | act[2])) != '0);
         default: blocked = 1'b0;
      endcase
   end

   // ---------------- scheduler FSM ----------------
   state_t state, state_nxt;
   logic   launch, illegal;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // IDLE decodes the head directly so an unblocked request launches without
   // an extra CHECK cycle; a blocked head parks the FSM in CHECK.
   always_comb begin
      state_nxt = state;
      pop       = 1'b0;
      launch    = 1'b0;
      illegal   = 1'b0;
      case (state)
         IDLE, CHECK: begin
            if (empty) begin
               state_nxt = IDLE;
            end else if (hd_illegal) begin
               pop       = 1'b1;
               illegal   = 1'b1;
               state_nxt = (count > (AW+1)'(1)) ? CHECK : IDLE;
            end else if (!blocked) begin
               pop       = 1'b1;
               launch    = 1'b1;
               state_nxt = LAUNCH;
            end else begin
               state_nxt = CHECK;
            end
         end
         LAUNCH:  state_nxt = empty ? IDLE : CHECK;
         default: state_nxt = IDLE;
      endcase
      if (flush) begin
         state_nxt = IDLE;
         pop       = 1'b0;
         launch    = 1'b0;
         illegal   = 1'b0;
      end
   end

   always_comb begin
      launch_k = '0;
      if (launch && hd_kind != 2'd3) launch_k[hd_kind] = 1'b1;
   end

   // Start pulses are registered so they appear for exactly the LAUNCH cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pulse       <= '0;
         err_illegal <= 1'b0;
      end else begin
         for (int k = 0; k < 3; k++)
            pulse[k] <= launch_k[k] ? hd_mask : '0;
         if (illegal) err_illegal <= 1'b1;
      end
   end

   assign strm_g2f_start_pulse = pulse[0];
   assign strm_f2g_start_pulse = pulse[1];
   assign pcfg_start_pulse     = pulse[2];
endmodule

// File: tb/tb_glb_strm_launch_ctrl.sv
module tb_glb_strm_launch_ctrl;
   logic        clk = 1'b0, reset, flush, req_valid, req_ready, err_illegal;
   logic [23:0] cfg_timeout;
   logic [1:0]  req_kind;
   logic [15:0] req_tile_mask;
   logic [15:0] g2f_p, f2g_p, pcfg_p, g2f_irq, f2g_irq, pcfg_irq;
   logic [15:0] busy_g2f, busy_f2g, busy_pcfg;
   logic [2:0]  done_pulse, done_err;
   logic [15:0] seen_g, seen_o;
   int errs = 0, checks = 0;

   glb_strm_launch_ctrl #(.NUM_GLB_TILES(16), .FIFO_DEPTH(4), .TMO_WIDTH(24)) dut (
      .clk(clk), .reset(reset), .flush(flush), .cfg_timeout(cfg_timeout),
      .req_valid(req_valid), .req_ready(req_ready), .req_kind(req_kind),
      .req_tile_mask(req_tile_mask),
      .strm_g2f_start_pulse(g2f_p), .strm_f2g_start_pulse(f2g_p), .pcfg_start_pulse(pcfg_p),
      .strm_g2f_interrupt_pulse(g2f_irq), .strm_f2g_interrupt_pulse(f2g_irq),
      .pcfg_g2f_interrupt_pulse(pcfg_irq),
      .busy_g2f(busy_g2f), .busy_f2g(busy_f2g), .busy_pcfg(busy_pcfg),
      .done_pulse(done_pulse), .done_err(done_err), .err_illegal(err_illegal));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk); #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1; flush = 0; cfg_timeout = 0; req_valid = 0; req_kind = 0; req_tile_mask = 0;
      g2f_irq = 0; f2g_irq = 0; pcfg_irq = 0;
      repeat (2) @(posedge clk); #1;
      chk("rst_ready", req_ready, 1);
      chk("rst_pulses", g2f_p | f2g_p | pcfg_p, 0);
      chk("rst_busy", busy_g2f | busy_f2g | busy_pcfg, 0);
      chk("rst_done", {done_pulse, done_err}, 0);
      chk("rst_err", err_illegal, 0);
      reset = 0; step();

      // 1: g2f 0x0003, pulse at N+2, completion by two interrupts
      req_valid = 1; req_kind = 0; req_tile_mask = 16'h0003; step();
      req_valid = 0;
      chk("t1_pulse_n1", g2f_p, 0); step();
      chk("t1_pulse_n2", g2f_p, 16'h0003); step();
      chk("t1_pulse_off", g2f_p, 0);
      chk("t1_busy", busy_g2f, 16'h0003);
      g2f_irq = 16'h0001; step(); g2f_irq = 0;
      chk("t1_busy_half", busy_g2f, 16'h0002);
      chk("t1_no_done", done_pulse, 0);
      g2f_irq = 16'h0002; step(); g2f_irq = 0;
      chk("t1_busy_clr", busy_g2f, 0);
      chk("t1_done", done_pulse, 3'b001);
      chk("t1_done_err", done_err, 0); step();
      chk("t1_done_off", done_pulse, 0);

      // 2: pcfg blocked behind busy g2f tile 0
      req_valid = 1; req_kind = 0; req_tile_mask = 16'h0001; step();
      req_kind = 2; step();
      req_valid = 0;
      chk("t2_g2f_pulse", g2f_p, 16'h0001);
      for (int i = 0; i < 3; i++) begin
         step(); chk("t2_pcfg_held", pcfg_p, 0);
      end
      g2f_irq = 16'h0001; step(); g2f_irq = 0;
      chk("t2_g2f_done", done_pulse, 3'b001);
      chk("t2_pcfg_m1", pcfg_p, 0); step();
      chk("t2_pcfg_pulse", pcfg_p, 16'h0001); step();
      chk("t2_busy_pcfg", busy_pcfg, 16'h0001);

      // 3: head blocked by pcfg on tile 0, 5 back-to-back g2f requests
      req_valid = 1; req_kind = 0; req_tile_mask = 16'h0001;
      for (int i = 0; i < 4; i++) begin
         chk("t3_ready_fill", req_ready, 1); step();
      end
      chk("t3_full", req_ready, 0); step();
      chk("t3_full_hold", req_ready, 0);
      chk("t3_blocked", g2f_p, 0);
      pcfg_irq = 16'h0001; step(); pcfg_irq = 0;
      chk("t3_pcfg_done", done_pulse, 3'b100);
      chk("t3_still_full", req_ready, 0); step();
      chk("t3_ready_back", req_ready, 1);
      chk("t3_launch0", g2f_p, 16'h0001); step();
      req_valid = 0;
      for (int i = 0; i < 4; i++) begin
         g2f_irq = 16'h0001; step(); g2f_irq = 0;
         chk("t3_done_i", done_pulse, 3'b001); step();
         chk("t3_launch_i", g2f_p, 16'h0001);
      end
      g2f_irq = 16'h0001; step(); g2f_irq = 0;
      chk("t3_last_done", done_pulse, 3'b001);
      chk("t3_idle_busy", busy_g2f, 0);
      chk("t3_idle_ready", req_ready, 1);

      // 4: f2g timeout after 10 cycles
      cfg_timeout = 24'd10;
      req_valid = 1; req_kind = 1; req_tile_mask = 16'h8000; step();
      req_valid = 0; step();
      chk("t4_pulse", f2g_p, 16'h8000);
      for (int i = 1; i < 10; i++) begin
         step(); chk("t4_no_done", done_pulse, 0);
      end
      step();
      chk("t4_tmo_done", done_pulse, 3'b010);
      chk("t4_tmo_err", done_err, 3'b010);
      chk("t4_busy_clr", busy_f2g, 0);
      cfg_timeout = 0; step();

      // 5: illegal kind and zero mask dropped, next request launches
      chk("t5_err_pre", err_illegal, 0);
      req_valid = 1; req_kind = 3; req_tile_mask = 16'h0005; step();
      req_kind = 0; req_tile_mask = 16'h0000; step();
      req_tile_mask = 16'h0010; step();
      req_valid = 0; seen_g = 0; seen_o = 0;
      for (int i = 0; i < 8; i++) begin
         seen_g |= g2f_p; seen_o |= f2g_p | pcfg_p; step();
      end
      chk("t5_g2f_only", seen_g, 16'h0010);
      chk("t5_no_other", seen_o, 0);
      chk("t5_err", err_illegal, 1);
      g2f_irq = 16'h0010; step(); g2f_irq = 0;
      chk("t5_done", done_pulse, 3'b001);

      // 6: flush clears busy without done, err_illegal kept
      req_valid = 1; req_kind = 0; req_tile_mask = 16'h0004; step();
      req_valid = 0; step();
      chk("t6_pulse", g2f_p, 16'h0004); step();
      chk("t6_busy", busy_g2f, 16'h0004);
      flush = 1; step(); flush = 0;
      chk("t6_busy_flush", busy_g2f, 0);
      chk("t6_no_done", done_pulse, 0);
      chk("t6_err_kept", err_illegal, 1);
      g2f_irq = 16'h0004; step(); g2f_irq = 0;
      chk("t6_late_irq", done_pulse, 0);

      // 7: reset during the LAUNCH cycle
      req_valid = 1; req_kind = 0; req_tile_mask = 16'h0003; step();
      req_valid = 0; step();
      chk("t7_pulse", g2f_p, 16'h0003);
      reset = 1; #1;
      chk("t7_async_drop", g2f_p, 0);
      @(posedge clk); #1; reset = 0;
      chk("t7_busy", busy_g2f, 0);
      chk("t7_ready", req_ready, 1);
      chk("t7_err_clr", err_illegal, 0);
      g2f_irq = 16'h0003; step(); g2f_irq = 0;
      chk("t7_late_irq", done_pulse, 0);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
